// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU run controller: FSM state encoding and the default halt opcode.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FILL,
    ST_RUN,
    ST_DONE,
    ST_TOUT
  } state_t;

  localparam logic [3:0] HALT_OP_DEF = 4'b1111;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; count_next exposes the value the next enabled edge will load.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next
);

  assign count_next = (count == '1) ? count : count + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count_next;
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Streams a program into instruction memory (zero-padding the tail), then runs the CPU until halt or timeout.
// Memory-write outputs are registered: each accepted word shows up on im_* the cycle after the accepting edge.
module cpu_run_ctrl
  import cpu_pkg::*;
#(
  parameter int         INST_W     = 8,
  parameter int         ADDR_W     = 4,
  parameter int         CNT_W      = 16,
  parameter int         MAX_CYCLES = 1000,
  parameter logic [3:0] HALT_OP    = HALT_OP_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [INST_W-1:0] load_data,
  input  logic              load_last,
  input  logic              start,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [INST_W-1:0] im_wdata,
  output logic              cpu_rst,
  input  logic [INST_W-1:0] instruction,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              truncated,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [CNT_W-1:0]  TOUT_CNT  = CNT_W'(MAX_CYCLES - 1);

  state_t state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt, wr_addr;
  logic [INST_W-1:0] wr_data;
  logic [CNT_W-1:0]  cnt_next;
  logic wr_en, accept, is_halt, cnt_clr, cnt_en;
  logic loaded, loaded_nxt, drain, drain_nxt;
  logic done_nxt, tout_nxt, trunc_nxt;
  logic unused_bits;

  assign accept      = load_valid && load_ready;
  assign is_halt     = (instruction[INST_W-1 -: 4] == HALT_OP);
  assign unused_bits = ^instruction[INST_W-5:0];

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr        (cnt_clr),
    .en         (cnt_en),
    .count      (cycle_count),
    .count_next (cnt_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    wr_en      = 1'b0;
    wr_addr    = ptr;
    wr_data    = load_data;
    loaded_nxt = loaded;
    drain_nxt  = drain;
    done_nxt   = done;
    tout_nxt   = timeout;
    trunc_nxt  = truncated;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE, ST_TOUT: begin
        // After a truncated load, the overflow of that stream is swallowed up to its last word.
        if (accept && drain) begin
          if (load_last)
            drain_nxt = 1'b0;
        end else if (accept) begin
          wr_en      = 1'b1;
          wr_addr    = '0;
          ptr_nxt    = ADDR_W'(1);
          loaded_nxt = 1'b0;
          done_nxt   = 1'b0;
          tout_nxt   = 1'b0;
          trunc_nxt  = 1'b0;
          state_nxt  = load_last ? ST_FILL : ST_LOAD;
        end else if (start && loaded) begin
          cnt_clr   = 1'b1;
          done_nxt  = 1'b0;
          tout_nxt  = 1'b0;
          state_nxt = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wr_en   = 1'b1;
          ptr_nxt = ptr + 1'b1;
          if (ptr == LAST_ADDR) begin
            state_nxt  = ST_IDLE;
            loaded_nxt = 1'b1;
            trunc_nxt  = !load_last;
            drain_nxt  = !load_last;
          end else if (load_last) begin
            state_nxt = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        wr_en   = 1'b1;
        wr_data = '0;
        ptr_nxt = ptr + 1'b1;
        if (ptr == LAST_ADDR) begin
          state_nxt  = ST_IDLE;
          loaded_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        // The halting cycle is counted too; halt wins over a simultaneous timeout.
        cnt_en = 1'b1;
        if (is_halt) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
        end else if (cnt_next == TOUT_CNT) begin
          state_nxt = ST_TOUT;
          tout_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr        <= '0;
      loaded     <= 1'b0;
      drain      <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      truncated  <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      load_ready <= 1'b0;
      busy       <= 1'b0;
      cpu_rst    <= 1'b1;
    end else begin
      ptr        <= ptr_nxt;
      loaded     <= loaded_nxt;
      drain      <= drain_nxt;
      done       <= done_nxt;
      timeout    <= tout_nxt;
      truncated  <= trunc_nxt;
      im_we      <= wr_en;
      if (wr_en) begin
        im_addr  <= wr_addr;
        im_wdata <= wr_data;
      end
      load_ready <= state_nxt inside {ST_IDLE, ST_LOAD, ST_DONE, ST_TOUT};
      busy       <= wr_en || (state_nxt inside {ST_LOAD, ST_FILL, ST_RUN});
      cpu_rst    <= (state_nxt != ST_RUN);
    end
  end

endmodule
